// File: rtl/cpu_clock_sequencer_pkg.sv
// Shared types and divide-code tables for the CPU clock sequencer.
// Imported by cpu_clock_sequencer.
package cpu_clkseq_pkg;

    typedef enum logic [1:0] {
        RUN_LO  = 2'd0,
        RUN_HI  = 2'd1,
        STOPPED = 2'd2
    } clk_state_e;

    localparam logic [1:0] DIV_2 = 2'd0;
    localparam logic [1:0] DIV_3 = 2'd1;
    localparam logic [1:0] DIV_4 = 2'd2;
    localparam logic [1:0] DIV_6 = 2'd3;

    typedef struct packed {
        logic [2:0] high_len;
        logic [2:0] low_len;
    } phase_len_t;

    // High/low phase lengths in master cycles for a divide code.
    function automatic phase_len_t phase_len(input logic [1:0] code);
        phase_len_t r;
        case (code)
            DIV_2:   r = '{high_len: 3'd1, low_len: 3'd1};
            DIV_3:   r = '{high_len: 3'd2, low_len: 3'd1};
            DIV_4:   r = '{high_len: 3'd2, low_len: 3'd2};
            default: r = '{high_len: 3'd3, low_len: 3'd3};
        endcase
        return r;
    endfunction

endpackage

// File: rtl/cpu_clock_sequencer_if.sv
// Control and status bundle of the CPU clock sequencer.
// master = CPU/bus timing side, slave = the sequencer itself.
interface cpu_clock_sequencer_if;
    logic [1:0] DIV_SEL;
    logic       DIV_LD;
    logic       STOP_REQ;
    logic       RUN_REQ;
    logic       WAIT;
    logic       CPUCLK;
    logic       CPU_RISE;
    logic       CPU_FALL;
    logic       RUNNING;
    logic       STOPPED;
    logic [1:0] DIV_CUR;

    modport master (
        output DIV_SEL, DIV_LD, STOP_REQ, RUN_REQ, WAIT,
        input  CPUCLK, CPU_RISE, CPU_FALL, RUNNING, STOPPED, DIV_CUR
    );

    modport slave (
        input  DIV_SEL, DIV_LD, STOP_REQ, RUN_REQ, WAIT,
        output CPUCLK, CPU_RISE, CPU_FALL, RUNNING, STOPPED, DIV_CUR
    );
endinterface

// File: rtl/cpu_clock_sequencer_sync_sr_flag.sv
// Synchronous set/reset flag replacing a cross-coupled NAND latch.
// Priority: clr (synchronous clear) > set > reset.
module sync_sr_flag (
    input  logic clk,
    input  logic clr,
    input  logic set,
    input  logic reset,
    output logic q
);

    // Set-dominant flag update with an overriding synchronous clear.
    always_ff @(posedge clk) begin
        if (clr)
            q <= 1'b0;
        else if (set)
            q <= 1'b1;
        else if (reset)
            q <= 1'b0;
    end

endmodule

// File: rtl/cpu_clock_sequencer.sv
// CPU clock sequencer: divided CPU clock level with rise/fall strobes,
// programmable divide, wait-state stretching and stop/run control.
// Optional feature macro: CPU_CLKSEQ_WAIT_EN (WAIT stretching of high phase).
module cpu_clock_sequencer
    import cpu_clkseq_pkg::*;
(
    input  logic                        CLOCK,
    input  logic                        RESET,
    cpu_clock_sequencer_if.slave        bus
);

    clk_state_e state;
    logic [2:0] cnt;
    logic       ld_pend;
    logic [1:0] div_pend;
    logic [1:0] div_cur;
    logic       cpuclk;
    logic       cpu_rise;
    logic       cpu_fall;
    logic       running;
    logic       stopped;

    phase_len_t len;
    logic       lo_end;
    logic       hi_end;
    logic       stop_pend;
    logic       stop_clr;
    logic       stop_set;
    logic       wait_hold;

    // Phase lengths of the applied divide code and end-of-phase decodes.
    always_comb begin
        len    = phase_len(div_cur);
        lo_end = (state == RUN_LO) && (cnt == len.low_len - 3'd1);
        hi_end = (state == RUN_HI) && (cnt == len.high_len - 3'd1);
    end

`ifdef CPU_CLKSEQ_WAIT_EN
    // WAIT holds the clock high once the nominal high time is used up.
    always_comb begin
        wait_hold = bus.WAIT;
    end
`else
    logic unused_wait;

    // WAIT is accepted on the bus but has no effect in this build.
    always_comb begin
        unused_wait = bus.WAIT;
        wait_hold   = 1'b0;
    end
`endif

    // Stop-pending control: cleared on reset or when the stop is taken.
    always_comb begin
        stop_clr = RESET | (lo_end & stop_pend);
        stop_set = bus.STOP_REQ & (state != STOPPED);
    end

    sync_sr_flag u_stop_flag (
        .clk   (CLOCK),
        .clr   (stop_clr),
        .set   (stop_set),
        .reset (bus.RUN_REQ),
        .q     (stop_pend)
    );

    // Clock FSM, phase counter, divide registers and registered outputs.
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state    <= RUN_LO;
            cnt      <= '0;
            ld_pend  <= 1'b0;
            div_pend <= '0;
            div_cur  <= DIV_2;
            cpuclk   <= 1'b0;
            cpu_rise <= 1'b0;
            cpu_fall <= 1'b0;
            running  <= 1'b1;
            stopped  <= 1'b0;
        end else begin
            cpu_rise <= 1'b0;
            cpu_fall <= 1'b0;

            if (bus.DIV_LD && (state != STOPPED)) begin
                ld_pend  <= 1'b1;
                div_pend <= bus.DIV_SEL;
            end

            case (state)
                RUN_LO: begin
                    if (lo_end) begin
                        cnt <= '0;
                        if (stop_pend) begin
                            state   <= STOPPED;
                            running <= 1'b0;
                            stopped <= 1'b1;
                        end else begin
                            state    <= RUN_HI;
                            cpuclk   <= 1'b1;
                            cpu_rise <= 1'b1;
                            ld_pend  <= 1'b0;
                            // A load in this very cycle beats an older pending one.
                            if (bus.DIV_LD)
                                div_cur <= bus.DIV_SEL;
                            else if (ld_pend)
                                div_cur <= div_pend;
                        end
                    end else begin
                        cnt <= cnt + 3'd1;
                    end
                end

                RUN_HI: begin
                    if (hi_end) begin
                        if (!wait_hold) begin
                            state    <= RUN_LO;
                            cnt      <= '0;
                            cpuclk   <= 1'b0;
                            cpu_fall <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 3'd1;
                    end
                end

                STOPPED: begin
                    cnt <= '0;
                    if (bus.DIV_LD) begin
                        div_cur <= bus.DIV_SEL;
                        ld_pend <= 1'b0;
                    end
                    if (bus.RUN_REQ) begin
                        state    <= RUN_HI;
                        cpuclk   <= 1'b1;
                        cpu_rise <= 1'b1;
                        running  <= 1'b1;
                        stopped  <= 1'b0;
                        if (!bus.DIV_LD && ld_pend) begin
                            div_cur <= div_pend;
                            ld_pend <= 1'b0;
                        end
                    end
                end

                default: begin
                    state   <= RUN_LO;
                    cnt     <= '0;
                    cpuclk  <= 1'b0;
                    running <= 1'b1;
                    stopped <= 1'b0;
                end
            endcase
        end
    end

    // Drive the status side of the bus from the output registers.
    always_comb begin
        bus.CPUCLK   = cpuclk;
        bus.CPU_RISE = cpu_rise;
        bus.CPU_FALL = cpu_fall;
        bus.RUNNING  = running;
        bus.STOPPED  = stopped;
        bus.DIV_CUR  = div_cur;
    end

endmodule

// File: doc/cpu_clock_sequencer.md
# cpu_clock_sequencer

Generates the CPU clock from the master clock domain as a registered divided clock level with one-cycle rise/fall strobes. It supports a programmable divide ratio and bus wait-state stretching. Stop/run is controlled by a synchronous set/reset flag, the clocked replacement for the cross-coupled NAND latch in the clock net. It sits in the clock block between the master clock and the CPU/bus timing logic.

## Interface
- No parameters; divide codes are fixed in the package.
- CLOCK  in  1  master clock; all state changes on the rising edge
- RESET  in  1  synchronous, active-high reset
- DIV_SEL  in  2  divide code: 0 = /2, 1 = /3, 2 = /4, 3 = /6
- DIV_LD  in  1  one-cycle strobe; capture DIV_SEL
- STOP_REQ  in  1  pulse; request clock stop
- RUN_REQ  in  1  pulse; request clock run / cancel pending stop
- WAIT  in  1  stretch the current high phase
- CPUCLK  out  1  divided CPU clock level; reset 0
- CPU_RISE  out  1  high in the first cycle CPUCLK reads 1; reset 0
- CPU_FALL  out  1  high in the first cycle CPUCLK reads 0 after a high phase; reset 0
- RUNNING  out  1  1 in RUN_HI/RUN_LO; reset 1
- STOPPED  out  1  1 in STOPPED; reset 0
- DIV_CUR  out  2  applied divide code; reset 0 (/2)

## Operation
- All outputs are registered.
- State machine: RUN_LO, RUN_HI, STOPPED. Reset state is RUN_LO with phase count 0, stop-pending 0, load-pending 0.
- Phase lengths in master cycles (high/low): /2 = 1/1, /3 = 2/1, /4 = 2/2, /6 = 3/3.
- A 3-bit phase counter counts from 0. It reloads 0 on every phase change.
- RUN_LO, count == low_len-1, stop-pending 0 -> RUN_HI. CPUCLK goes to 1 and CPU_RISE pulses.
- RUN_LO, count == low_len-1, stop-pending 1 -> STOPPED. CPUCLK stays 0, no CPU_RISE, stop-pending clears.
- RUN_HI, count == high_len-1, WAIT = 0 -> RUN_LO. CPUCLK goes to 0 and CPU_FALL pulses.
- RUN_HI, count == high_len-1, WAIT = 1 -> stay in RUN_HI with the counter held. WAIT is re-sampled every cycle.
- STOPPED + RUN_REQ -> RUN_HI on the next edge. CPUCLK = 1 and CPU_RISE = 1 in the cycle after RUN_REQ is sampled.
- Stop-pending flag:
  - Set by STOP_REQ, cleared by RUN_REQ.
  - If both are asserted in the same cycle, stop wins (set dominant).
  - STOP_REQ while STOPPED is ignored.
- Divide load:
  - While running, DIV_LD captures DIV_SEL into a pending register. A later DIV_LD overwrites it.
  - The pending value is applied on the transition into RUN_HI. DIV_CUR updates in the same cycle CPU_RISE pulses.
  - While STOPPED, DIV_LD applies directly; DIV_CUR updates the next cycle.
  - DIV_LD in the same cycle as a RUN_LO->RUN_HI transition is applied at that transition.
- RESET overrides everything, including WAIT and pending requests. Mid-operation it returns all outputs to their reset values on the next edge and clears both pending flags.

## Timing
- First edge with RESET = 0 completes the /2 low phase. CPUCLK reads 1 and CPU_RISE pulses after that edge.
- Nominal CPUCLK period equals the divide ratio. WAIT adds exactly one master cycle of high time per cycle asserted.
- Stop latency: the clock always completes the current high and low phases before stopping. CPUCLK never shows a phase shorter than nominal.
- Restart latency: 1 cycle from the RUN_REQ sample to CPU_RISE.
- CPU_RISE and CPU_FALL are never high together. They are never high while STOPPED.

## Configuration
- CPU_CLKSEQ_WAIT_EN defined: WAIT stretching operates as specified.
- CPU_CLKSEQ_WAIT_EN undefined: the WAIT port remains but is ignored. The high phase always ends at high_len-1, and the WAIT sampling logic is not built.

## Structure
- Package cpu_clkseq_pkg holds:
  - the state enum (RUN_LO, RUN_HI, STOPPED)
  - divide code localparams
  - a function returning high_len/low_len for a 2-bit code
- Sub-module sync_sr_flag holds the stop-pending flag: a synchronous set-dominant set/reset register with synchronous clear. It is reused wherever the clock net's latches are converted.
- The top level contains the FSM, the phase counter and the divide registers.

## Test plan
- Reset, then free run /2 -> CPUCLK 1,0,1,0 from the first edge after reset; CPU_RISE every 2 cycles; RUNNING = 1, DIV_CUR = 0.
- DIV_SEL = 3 with DIV_LD during a /2 high phase -> that high and the following low phase complete at /2. From the next rise: 3 high / 3 low, with DIV_CUR = 3 in the CPU_RISE cycle.
- /3, WAIT held for 3 cycles starting at the last high cycle -> high lasts 2+3 = 5 cycles, then 1 low cycle, CPU_FALL once (with CPU_CLKSEQ_WAIT_EN). Without the macro -> high lasts 2 cycles.
- /4, STOP_REQ mid high phase -> high and low complete. STOPPED = 1 in the cycle the rise would have occurred, CPUCLK = 0. RUN_REQ then gives CPU_RISE on the next cycle.
- STOP_REQ and RUN_REQ in the same cycle while running -> the clock stops at the end of the next low phase.
- RESET during a /6 high phase with a stop and a load pending -> next cycle CPUCLK = 0, DIV_CUR = 0, RUNNING = 1. No stop occurs afterwards.
